// File: rtl/call_arbiter.sv
// call_arbiter: round-robin dispatch of latched seat call lights to one attendant (define PRIORITY_SEAT_EN to make seat 0 win ahead of round-robin)
module call_arbiter #(
  parameter int N_SEATS     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SEATS-1:0] call,
  input  logic [N_SEATS-1:0] cancel,
  input  logic               ack,
  input  logic               done,
  output logic [N_SEATS-1:0] light_state,
  output logic               dispatch_valid,
  output logic [IDX_W-1:0]   dispatch_seat,
  output logic               busy,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, DISPATCH, SERVING} state_t;
  state_t state, state_nxt;
  logic [N_SEATS-1:0] light_nxt;
  logic [IDX_W-1:0] seat_nxt, rr, rr_nxt, pick, scan, seat_inc, rr_ack;
  logic [7:0] cnt, cnt_nxt;
  logic to_nxt, served_done;
  assign dispatch_valid = state == DISPATCH;
  assign busy = state == SERVING;
  assign served_done = busy && done;
  assign seat_inc = (dispatch_seat == IDX_W'(N_SEATS-1)) ? '0 : dispatch_seat + 1'b1;
`ifdef PRIORITY_SEAT_EN
  assign rr_ack = (dispatch_seat == '0) ? rr : seat_inc;
`else
  assign rr_ack = seat_inc;
`endif
  always_comb begin
    light_nxt = light_state;
    for (int i = 0; i < N_SEATS; i++)
      light_nxt[i] = call[i] || (!cancel[i] && light_state[i] && !(served_done && dispatch_seat == IDX_W'(i)));
  end
  always_comb begin
    pick = rr;
    scan = '0;
    for (int k = N_SEATS-1; k >= 0; k--) begin
      scan = IDX_W'((int'(rr) + k) % N_SEATS);
      pick = light_state[scan] ? scan : pick;
    end
`ifdef PRIORITY_SEAT_EN
    pick = light_state[0] ? '0 : pick;
`endif
  end
  always_comb begin
    state_nxt = state;
    seat_nxt = dispatch_seat;
    rr_nxt = rr;
    cnt_nxt = cnt;
    to_nxt = 1'b0;
    case (state)
      IDLE: if (|light_state) begin
        state_nxt = DISPATCH;
        seat_nxt = pick;
        cnt_nxt = '0;
      end
      DISPATCH: if (ack) begin
        state_nxt = SERVING;
        rr_nxt = rr_ack;
      end else if (!light_nxt[dispatch_seat]) begin
        state_nxt = IDLE;
      end else if (cnt == 8'(TIMEOUT_CYC-1)) begin
        state_nxt = IDLE;
        to_nxt = 1'b1;
        rr_nxt = seat_inc;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
      SERVING: state_nxt = (done || !light_nxt[dispatch_seat]) ? IDLE : SERVING;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      light_state <= '0;
      dispatch_seat <= '0;
      rr <= '0;
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      light_state <= light_nxt;
      dispatch_seat <= seat_nxt;
      rr <= rr_nxt;
      cnt <= cnt_nxt;
      timeout <= to_nxt;
    end
  end
endmodule

// File: tb/tb_call_arbiter.sv
// tb_call_arbiter: directed and randomized checks of call_arbiter against a behavioural seat model
module tb_call_arbiter;
  localparam int N = 4;
  localparam int T = 8;
`ifdef PRIORITY_SEAT_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] call = '0, cancel = '0;
  logic ack = 1'b0, done = 1'b0;
  logic [3:0] light_state;
  logic dispatch_valid, busy, timeout;
  logic [1:0] dispatch_seat;
  int n_pass = 0, n_fail = 0, n_total = 0;
  bit [3:0] m_light;
  int m_mode, m_seat, m_ptr, m_offered;
  bit m_to;
  always #5 clk = ~clk;
  call_arbiter #(.N_SEATS(N), .IDX_W(2), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .call(call), .cancel(cancel), .ack(ack), .done(done),
    .light_state(light_state), .dispatch_valid(dispatch_valid), .dispatch_seat(dispatch_seat),
    .busy(busy), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask
  function automatic int pick_seat();
    int best = -1, bestd = N;
    for (int i = 0; i < N; i++)
      if (m_light[i] && ((i - m_ptr + N) % N) < bestd) begin
        best = i;
        bestd = (i - m_ptr + N) % N;
      end
    return (PRIO && m_light[0]) ? 0 : best;
  endfunction
  task automatic model_edge(input logic [3:0] c, input logic [3:0] x, input logic a, input logic d, input logic r);
    bit [3:0] nl;
    if (!r) begin
      m_light = '0; m_mode = 0; m_seat = 0; m_ptr = 0; m_offered = 0; m_to = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      nl[i] = c[i] ? 1'b1 : x[i] ? 1'b0 : (m_mode == 2 && d && i == m_seat) ? 1'b0 : m_light[i];
    m_to = 0;
    if (m_mode == 0) begin
      if (m_light != 0) begin
        m_seat = pick_seat(); m_mode = 1; m_offered = 1;
      end
    end else if (m_mode == 1) begin
      if (a) begin
        m_mode = 2;
        if (!(PRIO && m_seat == 0)) m_ptr = (m_seat + 1) % N;
      end else if (!nl[m_seat]) m_mode = 0;
      else if (m_offered == T) begin
        m_to = 1; m_ptr = (m_seat + 1) % N; m_mode = 0;
      end else m_offered++;
    end else if (d || !nl[m_seat]) m_mode = 0;
    m_light = nl;
  endtask
  task automatic step(input logic [3:0] c, input logic [3:0] x, input logic a, input logic d, input logic r = 1'b1);
    call = c; cancel = x; ack = a; done = d; rst_n = r;
    @(posedge clk);
    model_edge(c, x, a, d, r);
    #1;
    chk("light", light_state, m_light);
    chk("valid", dispatch_valid, m_mode == 1);
    chk("seat", dispatch_seat, m_seat);
    chk("busy", busy, m_mode == 2);
    chk("timeout", timeout, m_to);
  endtask
  initial begin
    int ord3[3] = '{0, 1, 3};
    int ord2[2] = '{0, 3};
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_light", light_state, 0);
    chk("rst_valid", dispatch_valid, 0);
    chk("rst_busy", busy, 0);
    step(4'b0010, 0, 0, 0);
    chk("tp1_light", light_state, 4'b0010);
    chk("tp1_novalid", dispatch_valid, 0);
    step(0, 0, 0, 0);
    chk("tp1_valid", dispatch_valid, 1);
    chk("tp1_seat", dispatch_seat, 1);
    step(0, 0, 1, 0);
    chk("tp1_busy", busy, 1);
    step(0, 0, 0, 1);
    chk("tp1_clear", light_state, 0);
    chk("tp1_idle", busy, 0);
    step(0, 0, 0, 0, 0);
    step(4'b1011, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      chk("rr_order1", dispatch_seat, ord3[k]);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
    end
    step(4'b1001, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0);
      chk("rr_order2", dispatch_seat, ord2[k]);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
    end
    step(4'b0100, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("to_valid", dispatch_valid, 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0);
      chk("to_early", timeout, 0);
    end
    step(0, 0, 0, 0);
    chk("to_pulse", timeout, 1);
    chk("to_light", light_state[2], 1);
    chk("to_drop", dispatch_valid, 0);
    step(0, 0, 0, 0);
    chk("to_redisp", dispatch_seat, 2);
    chk("to_revalid", dispatch_valid, 1);
    chk("to_once", timeout, 0);
    step(0, 4'b0100, 0, 0);
    step(4'b0010, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 4'b0010, 0, 0);
    chk("cxl_disp_light", light_state[1], 0);
    chk("cxl_disp_valid", dispatch_valid, 0);
    chk("cxl_disp_busy", busy, 0);
    step(4'b0010, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("cxl_srv_busy1", busy, 1);
    step(0, 4'b0010, 0, 0);
    chk("cxl_srv_busy0", busy, 0);
    step(4'b0100, 4'b0100, 0, 0);
    chk("call_wins", light_state[2], 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_busy", busy, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_srv_light", light_state, 0);
    chk("rst_srv_busy", busy, 0);
    chk("rst_srv_seat", dispatch_seat, 0);
    step(4'b0001, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    chk("prio_to", timeout, 1);
    step(0, 0, 0, 0);
    chk("prio_seat", dispatch_seat, PRIO ? 0 : 2);
    for (int k = 0; k < 1500; k++)
      step(4'($urandom & $urandom & $urandom), 4'($urandom & $urandom & $urandom & $urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) != 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
